lisa_qqspi_engine: RTL and testbench
====================================

Name: lisa_qqspi_engine

Overview:
- QPI (4-bit) SPI master directly downstream of the LISA QSPI arbiter. It consumes the arbiter's single granted request stream and serialises it onto the external QSPI flash/PSRAM pins.
- Per transfer: command, 24-bit address, optional dummy cycles, then xfer_len 16-bit words, with per-word ready/ready_ack flow control and a final xfer_done pulse.

Parameters:
- CHIP_SELECTS, 2: number of external chip-enable lines.
- DUMMY_CYCLES, 6: SCK cycles between address and read data (reads only).
- CS_HOLD, 2: minimum clk cycles ce_n stays high after a transfer.
- CMD_QUAD_READ, 8'hEB: default read command.
- CMD_QUAD_WRITE, 8'h38: default write command.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- addr  in  24  transfer start address
- rdata  out  16  read word; valid while ready=1
- wdata  in  16  write word
- wstrb  in  2  00 = read; any non-zero = write (whole 16-bit word written)
- ready  out  1  word complete; held high until ready_ack
- ready_ack  in  1  client consumed/supplied word
- xfer_done  out  1  one-cycle pulse at end of transfer
- valid  in  1  request strobe; sampled only in IDLE
- xfer_len  in  4  word count; 0 means 16
- ce_ctrl  in  CHIP_SELECTS  bit i=1 asserts ce_n[i] during transfer
- custom_spi_cmd  in  1  1 = use cmd_quad_write for writes
- cmd_quad_write  in  8  custom write command
- sclk  out  1  SPI clock, idles low
- ce_n  out  CHIP_SELECTS  active-low chip enables
- sio_out  out  4  data to pads
- sio_oe  out  4  pad output enable (all bits equal)
- sio_in  in  4  data from pads

Behaviour:
- Reset (async, any state): state=IDLE; sclk=0, ce_n=all 1, sio_out=0, sio_oe=0, ready=0, xfer_done=0, rdata=0. This aborts any transfer in flight with no xfer_done.
- SCK period = 2 clk. Nibbles are driven while sclk=0. sclk rises on the next clk. Read nibbles are sampled on the clk edge where sclk falls. All data is MSB-nibble first.
- States: IDLE, CMD, ADDR, DUMMY, DATA, WAIT_ACK, CS_WAIT, DONE.
- IDLE -> CMD when valid=1. On the same edge, latch addr, wstrb, xfer_len, ce_ctrl, and the command: write = custom_spi_cmd ? cmd_quad_write : CMD_QUAD_WRITE; read = CMD_QUAD_READ. For writes, also latch wdata as word 0. ce_n = ~ce_ctrl from the next cycle. ce_ctrl=0 still runs the transfer with no CE asserted.
- CMD: 2 SCK (8-bit command). ADDR: 6 SCK (24 bits). sio_oe=1 in both.
- Reads: ADDR -> DUMMY (DUMMY_CYCLES SCK, sio_oe=0) -> DATA. If DUMMY_CYCLES=0, go directly to DATA.
- Writes: ADDR -> DATA with sio_oe=1.
- DATA: 4 SCK per word. After the 4th nibble completes, enter WAIT_ACK with sclk=0 held (clock stretched).
  - In WAIT_ACK: ready=1; rdata holds the assembled read word (reads).
  - On ready_ack=1 (may coincide with ready's first cycle): ready drops the next cycle; the word counter decrements.
  - If words remain, return to DATA; for writes, wdata is sampled on the ack edge as the next word.
  - If no words remain, go to CS_WAIT.
- CS_WAIT: ce_n=all 1, sio_oe=0, for CS_HOLD clk, then DONE.
- DONE: xfer_done=1 for exactly one cycle, then IDLE. A new valid is accepted no earlier than the cycle after DONE.
- valid in any non-IDLE state is ignored. valid may drop after the first ready (the arbiter's valid gating) without effect.
- Address is not incremented by the engine; the device auto-increments within the burst.
- Word counter: 5 bits; xfer_len=0 loads 16.
- Timing, read, DUMMY_CYCLES=6, 1 word: valid edge -> ce_n low at +1 -> ready high at +1+16+12+8 = 37 clk.

Test Plan:
- Read: valid with addr=24'h123456, wstrb=0, xfer_len=1, ce_ctrl=2'b01; sio_in returns nibbles A,B,C,D -> sio_out sequence E,B,1,2,3,4,5,6; sio_oe=0 during 6 dummy SCK; rdata=16'hABCD with ready at cycle 37; after ack, ce_n=2'b11 for 2 clk, then one xfer_done pulse.
- Write, 2 words: wdata 16'h1234 then 16'h5678 (changed on ack), custom_spi_cmd=1, cmd_quad_write=8'h02 -> nibbles 0,2, address nibbles, 1,2,3,4,5,6,7,8; no dummy; ready twice; sclk stays low while ack is withheld for 10 clk.
- xfer_len=0 read -> exactly 16 ready/ack handshakes before xfer_done.
- ready_ack held high continuously -> back-to-back words with no extra stall; ready high for 1 clk per word.
- Assert rst mid-DATA -> next clk edge shows ce_n=2'b11, sclk=0, sio_oe=0, ready=0, no xfer_done; a subsequent valid starts a clean transfer.
- valid pulsed during ADDR and during CS_WAIT -> ignored; the second request is accepted only after the xfer_done cycle.

Source files
------------

// File: rtl/lisa_qqspi_engine.sv
// lisa_qqspi_engine
// QPI (4-bit) SPI master fed by the LISA QSPI arbiter. One granted request is
// serialised as command, 24-bit address, optional dummy clocks (reads only),
// then xfer_len 16-bit words, each handed over with a ready/ready_ack handshake.
// SCK runs at clk/2. A nibble is launched while sclk is low, and read data is
// captured on the clk edge where sclk falls.
module lisa_qqspi_engine #(
    parameter int unsigned CHIP_SELECTS   = 2,
    parameter int unsigned DUMMY_CYCLES   = 6,
    parameter int unsigned CS_HOLD        = 2,
    parameter logic [7:0]  CMD_QUAD_READ  = 8'hEB,
    parameter logic [7:0]  CMD_QUAD_WRITE = 8'h38
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [23:0]             addr,
    output logic [15:0]             rdata,
    input  logic [15:0]             wdata,
    input  logic [1:0]              wstrb,
    output logic                    ready,
    input  logic                    ready_ack,
    output logic                    xfer_done,
    input  logic                    valid,
    input  logic [3:0]              xfer_len,
    input  logic [CHIP_SELECTS-1:0] ce_ctrl,
    input  logic                    custom_spi_cmd,
    input  logic [7:0]              cmd_quad_write,
    output logic                    sclk,
    output logic [CHIP_SELECTS-1:0] ce_n,
    output logic [3:0]              sio_out,
    output logic [3:0]              sio_oe,
    input  logic [3:0]              sio_in
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_DUMMY,
        S_DATA,
        S_WAIT_ACK,
        S_CS_WAIT,
        S_DONE
    } state_t;

    // Counter values on the last SCK (or clk, for CS_WAIT) of each phase.
    // A zero CS_HOLD still spends one clk in CS_WAIT.
    localparam logic [7:0] CMD_LAST   = 8'd1;
    localparam logic [7:0] ADDR_LAST  = 8'd5;
    localparam logic [7:0] DATA_LAST  = 8'd3;
    localparam logic [7:0] DUMMY_LAST = (DUMMY_CYCLES > 0) ? 8'(DUMMY_CYCLES - 1) : 8'd0;
    localparam logic [7:0] HOLD_LAST  = (CS_HOLD > 0) ? 8'(CS_HOLD - 1) : 8'd0;

    state_t      state;
    logic [7:0]  cnt;         // SCKs (or clks) completed in the current phase
    logic [4:0]  words_left;  // 1..16 words still to hand over
    logic        is_write;
    logic [27:0] hdr_sh;      // low command nibble + address, next nibble at [27:24]
    logic [15:0] wr_sh;       // write word, nibble on the pins at [15:12]
    logic [7:0]  start_cmd;

    // Command chosen for a request presented in IDLE.
    assign start_cmd = (|wstrb) ? (custom_spi_cmd ? cmd_quad_write : CMD_QUAD_WRITE)
                                : CMD_QUAD_READ;

    // Transfer sequencer: one registered FSM owns every pad and handshake output.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: every register is reset here (there is no memory array), so an
        // abort in any state leaves the pins idle and never emits xfer_done.
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            words_left <= '0;
            is_write   <= 1'b0;
            hdr_sh     <= '0;
            wr_sh      <= '0;
            sclk       <= 1'b0;
            ce_n       <= '1;
            sio_out    <= '0;
            sio_oe     <= '0;
            ready      <= 1'b0;
            xfer_done  <= 1'b0;
            rdata      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    xfer_done <= 1'b0;
                    if (valid) begin
                        is_write   <= |wstrb;
                        words_left <= (xfer_len == 4'd0) ? 5'd16 : {1'b0, xfer_len};
                        hdr_sh     <= {start_cmd[3:0], addr};
                        wr_sh      <= wdata;
                        sio_out    <= start_cmd[7:4];
                        sio_oe     <= 4'hF;
                        ce_n       <= ~ce_ctrl;
                        cnt        <= '0;
                        state      <= S_CMD;
                    end
                end

                S_CMD, S_ADDR: begin
                    if (!sclk) begin
                        sclk <= 1'b1;
                    end else begin
                        sclk    <= 1'b0;
                        hdr_sh  <= {hdr_sh[23:0], 4'h0};
                        sio_out <= hdr_sh[27:24];
                        cnt     <= cnt + 8'd1;
                        if (state == S_CMD && cnt == CMD_LAST) begin
                            cnt   <= '0;
                            state <= S_ADDR;
                        end else if (state == S_ADDR && cnt == ADDR_LAST) begin
                            // NOTE: with non-blocking assignments the last one in
                            // the block wins, so these override the shift above.
                            cnt <= '0;
                            if (is_write) begin
                                sio_out <= wr_sh[15:12];
                                state   <= S_DATA;
                            end else begin
                                sio_out <= '0;
                                sio_oe  <= '0;
                                state   <= (DUMMY_CYCLES == 0) ? S_DATA : S_DUMMY;
                            end
                        end
                    end
                end

                S_DUMMY: begin
                    if (!sclk) begin
                        sclk <= 1'b1;
                    end else begin
                        sclk <= 1'b0;
                        cnt  <= cnt + 8'd1;
                        if (cnt == DUMMY_LAST) begin
                            cnt   <= '0;
                            state <= S_DATA;
                        end
                    end
                end

                S_DATA: begin
                    if (!sclk) begin
                        sclk <= 1'b1;
                    end else begin
                        sclk <= 1'b0;
                        cnt  <= cnt + 8'd1;
                        if (is_write) begin
                            wr_sh   <= {wr_sh[11:0], 4'h0};
                            sio_out <= wr_sh[11:8];
                        end else begin
                            rdata <= {rdata[11:0], sio_in};
                        end
                        if (cnt == DATA_LAST) begin
                            cnt   <= '0;
                            ready <= 1'b1;
                            state <= S_WAIT_ACK;
                        end
                    end
                end

                // SCK is stretched low here until the client takes or supplies the word.
                S_WAIT_ACK: begin
                    if (ready_ack) begin
                        ready      <= 1'b0;
                        words_left <= words_left - 5'd1;
                        if (words_left == 5'd1) begin
                            ce_n    <= '1;
                            sio_oe  <= '0;
                            sio_out <= '0;
                            state   <= S_CS_WAIT;
                        end else begin
                            if (is_write) begin
                                wr_sh   <= wdata;
                                sio_out <= wdata[15:12];
                            end
                            state <= S_DATA;
                        end
                    end
                end

                S_CS_WAIT: begin
                    cnt <= cnt + 8'd1;
                    if (cnt == HOLD_LAST) begin
                        cnt       <= '0;
                        xfer_done <= 1'b1;
                        state     <= S_DONE;
                    end
                end

                S_DONE: begin
                    xfer_done <= 1'b0;
                    state     <= S_IDLE;
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lisa_qqspi_engine.sv
// tb_lisa_qqspi_engine
// Table-driven directed transfers, random transfers, and hand-written reset
// and ignored-valid sequences. A flash model answers read data. Every pin
// nibble seen during SCK-high is compared with a stream built from the
// transfer description.
`timescale 1ns/1ps
module tb_lisa_qqspi_engine;

    localparam int DUMMY = 6;
    localparam int HOLD  = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [23:0] addr = '0;
    logic [15:0] rdata;
    logic [15:0] wdata = '0;
    logic [1:0]  wstrb = '0;
    logic        ready;
    logic        ready_ack = 1'b0;
    logic        xfer_done;
    logic        valid = 1'b0;
    logic [3:0]  xfer_len = '0;
    logic [1:0]  ce_ctrl = '0;
    logic        custom_spi_cmd = 1'b0;
    logic [7:0]  cmd_quad_write = '0;
    logic        sclk;
    logic [1:0]  ce_n;
    logic [3:0]  sio_out;
    logic [3:0]  sio_oe;
    logic [3:0]  sio_in = '0;

    always #5 clk = ~clk;

    lisa_qqspi_engine #(
        .CHIP_SELECTS  (2),
        .DUMMY_CYCLES  (DUMMY),
        .CS_HOLD       (HOLD),
        .CMD_QUAD_READ (8'hEB),
        .CMD_QUAD_WRITE(8'h38)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .addr          (addr),
        .rdata         (rdata),
        .wdata         (wdata),
        .wstrb         (wstrb),
        .ready         (ready),
        .ready_ack     (ready_ack),
        .xfer_done     (xfer_done),
        .valid         (valid),
        .xfer_len      (xfer_len),
        .ce_ctrl       (ce_ctrl),
        .custom_spi_cmd(custom_spi_cmd),
        .cmd_quad_write(cmd_quad_write),
        .sclk          (sclk),
        .ce_n          (ce_n),
        .sio_out       (sio_out),
        .sio_oe        (sio_oe),
        .sio_in        (sio_in)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- flash model and pin capture ----------------
    logic [7:0]  cap [$];          // {sio_oe, sio_out} for every SCK-high phase
    int          sck_cnt  = 0;     // SCK-high phases seen so far
    int          sck_base = 0;     // sck_cnt at the start of the current transfer
    bit          dev_read = 1'b0;
    logic [15:0] dev_words [16];

    // Nibble the device returns after SCK-high phase idx of a read transfer.
    function automatic logic [3:0] dev_nibble(input int idx);
        int k;
        k = idx - (8 + DUMMY);
        if (!dev_read || k < 0 || k >= 64) return 4'($urandom);
        return dev_words[k / 4][15 - 4 * (k % 4) -: 4];
    endfunction

    always @(negedge clk) begin
        if (sclk === 1'b1) begin
            cap.push_back({sio_oe, sio_out});
            sio_in  <= dev_nibble(sck_cnt - sck_base);
            sck_cnt <= sck_cnt + 1;
        end
    end

    // ---------------- reference model ----------------
    function automatic logic [7:0] model_cmd(input logic [1:0] ws, input logic cu, input logic [7:0] cw);
        if (ws == 2'b00) return 8'hEB;
        return cu ? cw : 8'h38;
    endfunction

    typedef struct packed {
        logic [3:0] oe;
        logic [3:0] nib;
        logic       care;
    } exp_nib_t;

    typedef struct {
        logic [23:0] addr;
        logic [1:0]  wstrb;
        logic [3:0]  len;
        logic [1:0]  ce;
        logic        custom;
        logic [7:0]  cmdw;
        bit          hold;       // ready_ack held high for the whole transfer
        int          delay;      // clk cycles an ack is withheld after ready
        logic [15:0] d0;
        logic [15:0] d1;
        bit          poke;       // pulse valid in ADDR and raise it in CS_WAIT
        logic [7:0]  exp_cmd;
        int          exp_words;
    } vec_t;

    task automatic run_xfer(input vec_t v);
        bit          wr;
        int          n, t0, t_prev, k, cap_base;
        logic [1:0]  exp_ce;
        logic [15:0] words [16];
        exp_nib_t    exp_q [$];

        wr = (v.wstrb != 2'b00);
        n  = v.exp_words;
        for (int i = 0; i < 16; i++) words[i] = 16'($urandom);
        words[0] = v.d0;
        words[1] = v.d1;
        for (int i = 0; i < 16; i++) dev_words[i] = words[i];
        dev_read = !wr;

        @(negedge clk);
        sck_base       = sck_cnt;
        cap_base       = cap.size();
        valid          = 1'b1;
        addr           = v.addr;
        wstrb          = v.wstrb;
        xfer_len       = v.len;
        ce_ctrl        = v.ce;
        custom_spi_cmd = v.custom;
        cmd_quad_write = v.cmdw;
        wdata          = words[0];
        ready_ack      = v.hold;
        @(negedge clk);
        t0 = cyc;
        // Request fields must have been captured; scramble them.
        valid          = 1'b0;
        addr           = 24'($urandom);
        wstrb          = 2'($urandom);
        xfer_len       = 4'($urandom);
        ce_ctrl        = 2'($urandom);
        custom_spi_cmd = 1'($urandom);
        cmd_quad_write = 8'($urandom);
        wdata          = 16'($urandom);
        exp_ce         = ~v.ce;
        check("ce_n after accept", 32'(ce_n), 32'(exp_ce));

        t_prev = t0;
        for (int w = 0; w < n; w++) begin
            k = 0;
            while (ready !== 1'b1 && k < 400) begin
                @(negedge clk);
                k++;
                if (v.poke && w == 0) begin
                    if (cyc - t0 == 8) begin
                        valid = 1'b1;
                        addr  = 24'h0F0F0F;
                    end else if (cyc - t0 == 9) begin
                        valid = 1'b0;
                    end
                end
            end
            check($sformatf("ready seen word %0d", w), 32'(ready), 32'd1);
            if (ready !== 1'b1) return;
            if (w == 0)
                check("first word latency", 32'(cyc - t0), 32'(2 * (8 + (wr ? 0 : DUMMY) + 4)));
            else
                check($sformatf("word spacing %0d", w), 32'(cyc - t_prev), 32'(9 + v.delay));
            t_prev = cyc;
            if (!wr) check($sformatf("rdata word %0d", w), 32'(rdata), 32'(words[w]));
            for (int d = 0; d < v.delay; d++) begin
                @(negedge clk);
                check("stall sclk low, ready high", 32'({sclk, ready}), 32'd1);
            end
            ready_ack = 1'b1;
            wdata     = (w + 1 < n) ? words[w + 1] : 16'($urandom);
            @(negedge clk);
            ready_ack = v.hold;
            wdata     = 16'($urandom);
            check("ready drops after ack", 32'(ready), 32'd0);
        end

        k = 1;
        while (xfer_done !== 1'b1 && k < 20) begin
            check("CS_WAIT pins idle", 32'({ce_n, sclk, sio_oe}), 32'h60);
            if (v.poke && k == 1) begin
                valid          = 1'b1;
                addr           = 24'hABCDEF;
                wstrb          = 2'b00;
                xfer_len       = 4'd1;
                ce_ctrl        = 2'b10;
                custom_spi_cmd = 1'b0;
            end
            @(negedge clk);
            k++;
        end
        check("xfer_done after CS hold", 32'(k), 32'(HOLD + 1));
        check("ce_n high in DONE", 32'(ce_n), 32'h3);
        @(negedge clk);
        ready_ack = 1'b0;
        check("xfer_done single cycle", 32'(xfer_done), 32'd0);
        check("ce_n high after DONE", 32'(ce_n), 32'h3);

        // Expected pin stream: command, address, dummies, data words.
        exp_q.push_back('{4'hF, v.exp_cmd[7:4], 1'b1});
        exp_q.push_back('{4'hF, v.exp_cmd[3:0], 1'b1});
        for (int i = 5; i >= 0; i--) exp_q.push_back('{4'hF, v.addr[4 * i +: 4], 1'b1});
        if (!wr) for (int i = 0; i < DUMMY; i++) exp_q.push_back('{4'h0, 4'h0, 1'b0});
        for (int w = 0; w < n; w++)
            for (int j = 0; j < 4; j++)
                if (wr) exp_q.push_back('{4'hF, words[w][15 - 4 * j -: 4], 1'b1});
                else    exp_q.push_back('{4'h0, 4'h0, 1'b0});

        check("SCK count", 32'(cap.size() - cap_base), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && cap_base + i < cap.size(); i++) begin
            logic [7:0] c;
            c = cap[cap_base + i];
            check($sformatf("sio_oe sck %0d", i), 32'(c[7:4]), 32'(exp_q[i].oe));
            if (exp_q[i].care) check($sformatf("sio_out sck %0d", i), 32'(c[3:0]), 32'(exp_q[i].nib));
            if (c[7:4] !== exp_q[i].oe || (exp_q[i].care && c[3:0] !== exp_q[i].nib)) break;
        end
    endtask

    vec_t tbl [7];

    initial begin
        #4000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t v;
        int   t0;

        //              addr        wstrb  len    ce     cu    cmdw    hold dly d0        d1        poke cmd     words
        tbl[0] = '{addr: 24'h123456, wstrb: 2'b00, len: 4'd1, ce: 2'b01, custom: 1'b0, cmdw: 8'h00,
                   hold: 0, delay: 0, d0: 16'hABCD, d1: 16'h0000, poke: 0, exp_cmd: 8'hEB, exp_words: 1};
        tbl[1] = '{addr: 24'h00A5F0, wstrb: 2'b11, len: 4'd2, ce: 2'b10, custom: 1'b1, cmdw: 8'h02,
                   hold: 0, delay: 10, d0: 16'h1234, d1: 16'h5678, poke: 0, exp_cmd: 8'h02, exp_words: 2};
        tbl[2] = '{addr: 24'hFFFFFE, wstrb: 2'b00, len: 4'd0, ce: 2'b11, custom: 1'b0, cmdw: 8'h00,
                   hold: 0, delay: 0, d0: 16'h0F1E, d1: 16'hD2C3, poke: 0, exp_cmd: 8'hEB, exp_words: 16};
        tbl[3] = '{addr: 24'h800001, wstrb: 2'b01, len: 4'd4, ce: 2'b01, custom: 1'b0, cmdw: 8'h02,
                   hold: 1, delay: 0, d0: 16'hFFFF, d1: 16'h0000, poke: 0, exp_cmd: 8'h38, exp_words: 4};
        tbl[4] = '{addr: 24'h000000, wstrb: 2'b00, len: 4'd3, ce: 2'b00, custom: 1'b0, cmdw: 8'h00,
                   hold: 1, delay: 0, d0: 16'h8001, d1: 16'h7FFE, poke: 0, exp_cmd: 8'hEB, exp_words: 3};
        tbl[5] = '{addr: 24'h5A5A5A, wstrb: 2'b00, len: 4'd1, ce: 2'b10, custom: 1'b1, cmdw: 8'hAA,
                   hold: 0, delay: 2, d0: 16'h3C3C, d1: 16'h0000, poke: 0, exp_cmd: 8'hEB, exp_words: 1};
        tbl[6] = '{addr: 24'h13579B, wstrb: 2'b10, len: 4'd1, ce: 2'b01, custom: 1'b0, cmdw: 8'h55,
                   hold: 0, delay: 1, d0: 16'hC001, d1: 16'h0000, poke: 1, exp_cmd: 8'h38, exp_words: 1};

        // Reset state.
        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset sclk",      32'(sclk),      32'd0);
        check("reset ce_n",      32'(ce_n),      32'h3);
        check("reset sio_out",   32'(sio_out),   32'd0);
        check("reset sio_oe",    32'(sio_oe),    32'd0);
        check("reset ready",     32'(ready),     32'd0);
        check("reset xfer_done", 32'(xfer_done), 32'd0);
        check("reset rdata",     32'(rdata),     32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 7; i++) run_xfer(tbl[i]);

        // The request raised during CS_WAIT of the last entry is taken only
        // on the edge after DONE.
        @(negedge clk);
        t0 = cyc;
        valid = 1'b0;
        check("request after DONE accepted", 32'(ce_n), 32'h1);

        // Abort that read in the middle of its data phase.
        while (cyc - t0 < 32) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async reset pins idle", 32'({ce_n, sclk, sio_oe, ready, xfer_done}), 32'h180);
        @(posedge clk);
        #1;
        check("reset edge pins idle", 32'({ce_n, sclk, sio_oe, ready, xfer_done}), 32'h180);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("no xfer_done after abort", 32'({xfer_done, ce_n, ready}), 32'h6);
        end

        // Random transfers against the model.
        for (int r = 0; r < 12; r++) begin
            v.addr      = 24'($urandom);
            v.wstrb     = 2'($urandom);
            v.len       = 4'($urandom_range(0, 15));
            v.ce        = 2'($urandom);
            v.custom    = 1'($urandom);
            v.cmdw      = 8'($urandom);
            v.hold      = bit'($urandom_range(0, 1));
            v.delay     = v.hold ? 0 : int'($urandom_range(0, 3));
            v.d0        = 16'($urandom);
            v.d1        = 16'($urandom);
            v.poke      = 1'b0;
            v.exp_cmd   = model_cmd(v.wstrb, v.custom, v.cmdw);
            v.exp_words = (v.len == 4'd0) ? 16 : int'(v.len);
            run_xfer(v);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
